// File: rtl/block_serializer_if.sv
// block_serializer_if: parallel-block-in / serial-word-out handshake bundle
interface block_serializer_if #(parameter int DEPTH = 8, parameter int WIDTH = 8);
  logic ena_in;
  logic rdy_out;
  logic [WIDTH-1:0] in [DEPTH];
  logic ena_out;
  logic rdy_in;
  logic [WIDTH-1:0] out;
  logic last;
  modport master (output ena_in, in, rdy_in, input rdy_out, ena_out, out, last);
  modport slave (input ena_in, in, rdy_in, output rdy_out, ena_out, out, last);
endinterface

// File: rtl/block_serializer.sv
// block_serializer: double-buffered block-to-word serializer with zero-bubble block handover
module block_serializer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  block_serializer_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  logic [WIDTH-1:0] active [DEPTH];
  logic [WIDTH-1:0] pending [DEPTH];
  logic active_valid, pending_valid;
  logic [IW-1:0] idx;
  logic accept, emit, done;
  assign accept = bus.ena_in & !pending_valid;
  assign emit = active_valid & bus.rdy_in;
  assign done = emit & (idx == LAST_IDX);
  assign bus.rdy_out = !pending_valid;
  assign bus.ena_out = active_valid;
  assign bus.out = active[idx];
  assign bus.last = active_valid & (idx == LAST_IDX);
  // Bank contents are deliberately left out of reset; only the flags and idx matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_valid <= 1'b0;
      pending_valid <= 1'b0;
      idx <= '0;
    end else begin
      if (emit) idx <= done ? '0 : idx + IW'(1);
      if (!active_valid && accept) begin
        active <= bus.in;
        active_valid <= 1'b1;
        idx <= '0;
      end else if (done) begin
        if (pending_valid) begin
          active <= pending;
          pending_valid <= 1'b0;
        end else if (accept) begin
          active <= bus.in;
        end else begin
          active_valid <= 1'b0;
        end
      end else if (accept) begin
        pending <= bus.in;
        pending_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_block_serializer.sv
// tb_block_serializer: randomized scenario bench against a block-queue reference model
module tb_block_serializer;
  localparam int D = 4;
  localparam int W = 8;
  typedef logic [W-1:0] blk_t [D];
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  block_serializer_if #(.DEPTH(D), .WIDTH(W)) ifc ();
  block_serializer #(.DEPTH(D), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc));
  blk_t mq[$];
  int wpos = 0;
  int total = 0;
  int bad = 0;
  function automatic blk_t rblk();
    blk_t b;
    for (int i = 0; i < D; i++) b[i] = W'($urandom);
    return b;
  endfunction
  function automatic logic [W+2:0] exp_v();
    logic e;
    e = mq.size() > 0;
    return {e, mq.size() < 2, e && wpos == D - 1, e ? mq[0][wpos] : W'(0)};
  endfunction
  function automatic logic [W+2:0] obs_v();
    return {ifc.ena_out, ifc.rdy_out, ifc.last, ifc.ena_out ? ifc.out : W'(0)};
  endfunction
  task automatic tick(input logic e, input logic r, input logic rs, input blk_t b, output logic acc);
    logic em;
    ifc.ena_in = e;
    ifc.rdy_in = r;
    rst = rs;
    ifc.in = b;
    @(posedge clk);
    acc = 1'b0;
    if (rs) begin
      mq.delete();
      wpos = 0;
    end else begin
      acc = e && mq.size() < 2;
      em = mq.size() > 0 && r;
      if (em) begin
        wpos++;
        if (wpos == D) begin
          void'(mq.pop_front());
          wpos = 0;
        end
      end
      if (acc) mq.push_back(b);
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    logic a;
    tick(1'b1, 1'b1, 1'b1, rblk(), a);
    tick(1'b0, 1'b1, 1'b1, rblk(), a);
    if ({ifc.ena_out, ifc.last, ifc.rdy_out} !== 3'b001) begin
      bad++;
      $display("FAIL reset got ena_out/last/rdy_out=%b want=001", {ifc.ena_out, ifc.last, ifc.rdy_out});
    end
    total++;
  endtask
  task automatic test_single();
    logic a;
    blk_t b;
    b = '{8'd10, 8'd11, 8'd12, 8'd13};
    tick(1'b0, 1'b1, 1'b0, rblk(), a);
    tick(1'b1, 1'b1, 1'b0, b, a);
    for (int k = 0; k < D; k++) begin
      if ({ifc.ena_out, ifc.rdy_out, ifc.last, ifc.out} !== {2'b11, k == D - 1, W'(10 + k)}) begin
        bad++;
        $display("FAIL single word%0d got=%h want=%h", k, {ifc.ena_out, ifc.rdy_out, ifc.last, ifc.out},
                 {2'b11, k == D - 1, W'(10 + k)});
      end
      total++;
      tick(1'b0, 1'b1, 1'b0, rblk(), a);
    end
    if (ifc.ena_out !== 1'b0) begin
      bad++;
      $display("FAIL single_after got ena_out=%b want=0", ifc.ena_out);
    end
    total++;
  endtask
  task automatic test_back_to_back();
    logic a;
    blk_t blks [3];
    int n = 0;
    int seen = 0;
    for (int i = 0; i < 3; i++) blks[i] = rblk();
    for (int c = 0; c < 14 && seen < 3 * D; c++) begin
      tick(n < 3, 1'b1, 1'b0, n < 3 ? blks[n] : rblk(), a);
      if (a) n++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL b2b cyc%0d got=%h want=%h", c, obs_v(), exp_v());
      end
      total++;
      if (ifc.ena_out) begin
        if (ifc.out !== blks[seen / D][seen % D]) begin
          bad++;
          $display("FAIL b2b_stream word%0d got=%h want=%h", seen, ifc.out, blks[seen / D][seen % D]);
        end
        total++;
        seen++;
      end
    end
    if (seen !== 3 * D) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=%0d", seen, 3 * D);
    end
    total++;
  endtask
  task automatic test_backpressure();
    logic a;
    logic [7:0] pat = 8'b11011001;
    for (int c = 0; c < 48; c++) begin
      tick($urandom_range(0, 1) == 1, pat[c % 8], 1'b0, rblk(), a);
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL backpressure cyc%0d got=%h want=%h", c, obs_v(), exp_v());
      end
      total++;
    end
  endtask
  task automatic test_full();
    logic a;
    for (int c = 0; c < 8; c++) begin
      tick(1'b1, 1'b0, 1'b0, rblk(), a);
      if (obs_v() !== exp_v() || (c > 2 && ifc.rdy_out !== 1'b0)) begin
        bad++;
        $display("FAIL full cyc%0d got=%h want=%h", c, obs_v(), exp_v());
      end
      total++;
    end
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, 1'b1, 1'b0, rblk(), a);
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL full_drain cyc%0d got=%h want=%h", c, obs_v(), exp_v());
      end
      total++;
    end
  endtask
  task automatic test_zero_bubble();
    logic a;
    blk_t nb;
    nb = rblk();
    tick(1'b1, 1'b1, 1'b0, rblk(), a);
    for (int c = 0; c < 8 && !ifc.last; c++) tick(1'b0, 1'b1, 1'b0, rblk(), a);
    tick(1'b1, 1'b1, 1'b0, nb, a);
    if ({ifc.ena_out, ifc.last, ifc.out} !== {2'b10, nb[0]} || obs_v() !== exp_v()) begin
      bad++;
      $display("FAIL zero_bubble got=%h want=%h", {ifc.ena_out, ifc.last, ifc.out}, {2'b10, nb[0]});
    end
    total++;
  endtask
  task automatic test_reset_mid();
    logic a;
    blk_t nb;
    nb = rblk();
    for (int c = 0; c < 8 && ifc.ena_out; c++) tick(1'b0, 1'b1, 1'b0, rblk(), a);
    tick(1'b1, 1'b1, 1'b0, rblk(), a);
    tick(1'b1, 1'b1, 1'b0, rblk(), a);
    tick(1'b1, 1'b1, 1'b0, rblk(), a);
    if (ifc.rdy_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_pending got rdy_out=%b want=0", ifc.rdy_out);
    end
    total++;
    tick(1'b1, 1'b1, 1'b1, rblk(), a);
    if ({ifc.ena_out, ifc.rdy_out} !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid got ena_out/rdy_out=%b want=01", {ifc.ena_out, ifc.rdy_out});
    end
    total++;
    tick(1'b1, 1'b1, 1'b0, nb, a);
    if ({ifc.ena_out, ifc.out} !== {1'b1, nb[0]}) begin
      bad++;
      $display("FAIL reset_mid_restart got=%h want=%h", {ifc.ena_out, ifc.out}, {1'b1, nb[0]});
    end
    total++;
  endtask
  task automatic test_random();
    logic a;
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, rblk(), a);
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL random cyc%0d got=%h want=%h", c, obs_v(), exp_v());
      end
      total++;
    end
  endtask
  initial begin
    ifc.ena_in = 1'b0;
    ifc.rdy_in = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full();
    test_zero_bubble();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
